// File: rtl/fir_pkg.sv
// Shared constants for the FIR output FIFO: default sizes and the
// control state encoding used by fir_y_fifo.
package fir_pkg;

   localparam int FIR_DATA_W = 32;
   localparam int FIR_DEPTH  = 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_RUN   = RUN,
      ST_DRAIN = DRAIN,
      ST_DONE  = DONE
   } fir_state_t;

endpackage

// File: rtl/fir_y_fifo_mem.sv
// Storage array for the FIR output FIFO: one synchronous write port,
// one asynchronous read port so the head word falls through.
module fir_y_fifo_mem
   import fir_pkg::*;
#(
   parameter int pDATA_WIDTH = FIR_DATA_W,
   parameter int DEPTH       = FIR_DEPTH,
   parameter int PTR_W       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [PTR_W-1:0]       waddr,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0]       raddr,
   output logic [pDATA_WIDTH-1:0] rdata
);

   logic [pDATA_WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_y_fifo.sv
// Frame-aware FWFT FIFO between the FIR sm_* output and a downstream AXI-stream sink.
// Optional synchronous flush is compiled in with `define FIR_Y_FIFO_FLUSH_EN.
module fir_y_fifo
   import fir_pkg::*;
#(
   parameter int pDATA_WIDTH = FIR_DATA_W,
   parameter int DEPTH       = FIR_DEPTH,
   parameter int PTR_W       = $clog2(DEPTH)
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   start,
   input  logic [31:0]            len,
   input  logic                   s_tvalid,
   input  logic [pDATA_WIDTH-1:0] s_tdata,
   input  logic                   s_tlast,
   output logic                   s_tready,
   output logic                   m_tvalid,
   output logic [pDATA_WIDTH-1:0] m_tdata,
   output logic                   m_tlast,
   input  logic                   m_tready,
   output logic [PTR_W:0]         count,
   output logic                   busy,
   output logic                   done,
   output logic                   err_tlast,
   input  logic                   flush
);

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   fir_state_t             state, state_nxt;
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [PTR_W:0]         cnt_q, cnt_nxt;
   logic [31:0]            in_cnt, out_cnt, len_q, len_m1;
   logic                   err_q;
   logic                   wr_beat, rd_beat, start_go, flush_act;
   logic [pDATA_WIDTH-1:0] rd_data;

`ifdef FIR_Y_FIFO_FLUSH_EN
   assign flush_act = flush;
`else
   logic unused_flush;
   assign flush_act    = 1'b0;
   assign unused_flush = flush;
`endif

   assign len_m1   = len_q - 32'd1;
   assign s_tready = (state == ST_RUN) && (cnt_q != FULL);
   assign m_tvalid = (cnt_q != '0);
   assign wr_beat  = s_tvalid & s_tready;
   assign rd_beat  = m_tvalid & m_tready;
   assign start_go = (state == ST_IDLE) & start & ~flush_act;

   // Frame position comes from out_cnt, never from the stored s_tlast.
   assign m_tdata   = m_tvalid ? rd_data : '0;
   assign m_tlast   = m_tvalid & (out_cnt == len_m1);
   assign count     = cnt_q;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign err_tlast = err_q;

   fir_y_fifo_mem #(
      .pDATA_WIDTH (pDATA_WIDTH),
      .DEPTH       (DEPTH),
      .PTR_W       (PTR_W)
   ) u_mem (
      .clk   (axis_clk),
      .we    (wr_beat & ~flush_act),
      .waddr (wr_ptr),
      .wdata (s_tdata),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_comb begin
      cnt_nxt = cnt_q;
      case ({wr_beat, rd_beat})
         2'b10:   cnt_nxt = cnt_q + 1'b1;
         2'b01:   cnt_nxt = cnt_q - 1'b1;
         default: cnt_nxt = cnt_q;
      endcase
   end

   // DRAIN looks at the post-read occupancy so done follows the final read by one cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start) state_nxt = (len != 32'd0) ? ST_RUN : ST_DONE;
         ST_RUN:   if (wr_beat && (in_cnt == len_m1)) state_nxt = ST_DRAIN;
         ST_DRAIN: if (cnt_nxt == '0) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (flush_act) state_nxt = ST_IDLE;
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) state <= ST_IDLE;
      else             state <= state_nxt;
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else if (flush_act) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         cnt_q <= cnt_nxt;
         if (wr_beat) wr_ptr <= wr_ptr + 1'b1;
         if (rd_beat) rd_ptr <= rd_ptr + 1'b1;
         if (start_go) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            len_q   <= len;
            err_q   <= 1'b0;
         end else begin
            if (wr_beat) in_cnt  <= in_cnt + 32'd1;
            if (rd_beat) out_cnt <= out_cnt + 32'd1;
            if (wr_beat && (s_tlast != (in_cnt == len_m1))) err_q <= 1'b1;
         end
      end
   end

endmodule
